// File: rtl/level_meter_ctrl.sv
// level_meter_ctrl: turns a channel-tagged sample stream into four 4-bit bar
// levels. Peaks are tracked per frame. On each frame tick a sequencer walks
// the channels and applies peak-hold followed by a slow decay.
module level_meter_ctrl #(
  parameter int SAMPLE_W     = 8,
  parameter int HOLD_FRAMES  = 30,
  parameter int DECAY_FRAMES = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ena,
  input  logic                sample_valid,
  input  logic [1:0]          sample_ch,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                frame_tick,
  output logic [3:0]          s1,
  output logic [3:0]          s2,
  output logic [3:0]          s3,
  output logic [3:0]          s4,
  output logic                update,
  output logic                busy
);

  localparam logic [7:0] HOLD_INIT  = 8'(HOLD_FRAMES);
  localparam logic [7:0] DECAY_LAST = 8'(DECAY_FRAMES - 1);

  typedef enum logic [2:0] {IDLE, UPD0, UPD1, UPD2, UPD3, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0][3:0] pk_q, pk_d;
  logic [3:0][3:0] d_q, d_d;
  logic [3:0][7:0] h_q, h_d;
  logic [3:0][7:0] c_q, c_d;
  logic            update_q, update_d;
  logic            busy_q, busy_d;

  logic [SAMPLE_W-1:0] neg;
  logic [SAMPLE_W-2:0] mag;
  logic [3:0]          lvl;
  logic                upd_en;
  logic [1:0]          upd_ch;

  // Sample magnitude with the most negative code saturated, top 4 bits as level
  always_comb begin
    neg = -sample;
    mag = sample[SAMPLE_W-2:0];
    if (sample[SAMPLE_W-1]) begin
      mag = neg[SAMPLE_W-1] ? '1 : neg[SAMPLE_W-2:0];
    end
    lvl = mag[SAMPLE_W-2 -: 4];
  end

  // Sequencer next-state, per-channel hold/decay and peak capture
  always_comb begin
    state_d  = state_q;
    pk_d     = pk_q;
    d_d      = d_q;
    h_d      = h_q;
    c_d      = c_q;
    update_d = 1'b0;
    busy_d   = busy_q;
    upd_en   = 1'b0;
    upd_ch   = 2'd0;

    unique case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d = UPD0;
          busy_d  = 1'b1;
        end
      end
      UPD0: begin
        upd_en  = 1'b1;
        upd_ch  = 2'd0;
        state_d = UPD1;
      end
      UPD1: begin
        upd_en  = 1'b1;
        upd_ch  = 2'd1;
        state_d = UPD2;
      end
      UPD2: begin
        upd_en  = 1'b1;
        upd_ch  = 2'd2;
        state_d = UPD3;
      end
      UPD3: begin
        upd_en   = 1'b1;
        upd_ch   = 2'd3;
        update_d = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (upd_en) begin
      if (pk_q[upd_ch] > d_q[upd_ch]) begin
        d_d[upd_ch] = pk_q[upd_ch];
        h_d[upd_ch] = HOLD_INIT;
        c_d[upd_ch] = '0;
      end else if (h_q[upd_ch] != '0) begin
        h_d[upd_ch] = h_q[upd_ch] - 8'd1;
      end else if (c_q[upd_ch] == DECAY_LAST) begin
        c_d[upd_ch] = '0;
        if (d_q[upd_ch] != '0) begin
          d_d[upd_ch] = d_q[upd_ch] - 4'd1;
        end
      end else begin
        c_d[upd_ch] = c_q[upd_ch] + 8'd1;
      end
      pk_d[upd_ch] = '0;
    end

    // A sample for the channel being refreshed starts the next frame's peak
    if (sample_valid) begin
      if (upd_en && (sample_ch == upd_ch)) begin
        pk_d[sample_ch] = lvl;
      end else if (lvl > pk_q[sample_ch]) begin
        pk_d[sample_ch] = lvl;
      end
    end
  end

  // State registers, frozen while ena is low
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pk_q     <= '0;
      d_q      <= '0;
      h_q      <= '0;
      c_q      <= '0;
      update_q <= 1'b0;
      busy_q   <= 1'b0;
    end else if (ena) begin
      state_q  <= state_d;
      pk_q     <= pk_d;
      d_q      <= d_d;
      h_q      <= h_d;
      c_q      <= c_d;
      update_q <= update_d;
      busy_q   <= busy_d;
    end
  end

  assign s1     = d_q[0];
  assign s2     = d_q[1];
  assign s3     = d_q[2];
  assign s4     = d_q[3];
  assign update = update_q;
  assign busy   = busy_q;

endmodule
